wb_scaler: RTL

WB_SCALER -- requirements
Module: wb_scaler

---
 rtl/wb_scaler.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/wb_scaler.sv
// Frame white-balance scaler: accumulates per-channel sums over a frame, derives
// the channel means and a reference mean, then rewrites every pixel scaled by them.
module wb_scaler #(
  parameter int DATA_W  = 8,
  parameter int NUM_PIX = 76800,
  parameter int ADDR_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] red_in,
  input  logic [DATA_W-1:0] green_in,
  input  logic [DATA_W-1:0] blue_in,
  output logic [ADDR_W-1:0] addr_read,
  output logic              we,
  output logic [ADDR_W-1:0] addr_write,
  output logic [DATA_W-1:0] red_out,
  output logic [DATA_W-1:0] green_out,
  output logic [DATA_W-1:0] blue_out,
  output logic [DATA_W-1:0] mean_r,
  output logic [DATA_W-1:0] mean_g,
  output logic [DATA_W-1:0] mean_b,
  output logic [DATA_W-1:0] ref_mean
);

  localparam int ACC_W  = DATA_W + ADDR_W;
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = DATA_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [DATA_W-1:0] MAX_VAL   = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    MEAN  = 3'd2,
    REF   = 3'd3,
    SCALE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_reg;
  logic                mode_reg;
  logic                issue_reg;
  logic                rd_valid_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic [ACC_W-1:0]    acc_reg   [3];
  logic [DATA_W-1:0]   mean_reg  [3];
  logic [DATA_W-1:0]   out_reg   [3];
  logic [DATA_W-1:0]   ref_reg;

  logic [DATA_W-1:0]   pix_in    [3];
  logic [DATA_W-1:0]   mean_calc [3];
  logic [DATA_W-1:0]   scaled    [3];
  logic [DATA_W-1:0]   ref_calc;

  assign pix_in[0] = red_in;
  assign pix_in[1] = green_in;
  assign pix_in[2] = blue_in;

  assign red_out   = out_reg[0];
  assign green_out = out_reg[1];
  assign blue_out  = out_reg[2];
  assign mean_r    = mean_reg[0];
  assign mean_g    = mean_reg[1];
  assign mean_b    = mean_reg[2];
  assign ref_mean  = ref_reg;

  // One divider per channel serves both modes: only numerator and divisor swap roles.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [ACC_W-1:0]  acc_quot;
      logic [PROD_W-1:0] num;
      logic [PROD_W-1:0] den;
      logic [PROD_W-1:0] quot;

      assign acc_quot      = acc_reg[gi] / ACC_W'(NUM_PIX);
      assign mean_calc[gi] = (acc_quot > ACC_W'(MAX_VAL)) ? MAX_VAL : acc_quot[DATA_W-1:0];

      assign num  = mode_reg ? (PROD_W'(pix_in[gi]) * PROD_W'(ref_reg))
                             : (PROD_W'(pix_in[gi]) * PROD_W'(mean_reg[gi]));
      assign den  = mode_reg ? PROD_W'(mean_reg[gi]) : PROD_W'(ref_reg);
      assign quot = (den == '0) ? '0 : num / den;

      always_comb begin
        scaled[gi] = '0;
        if (den == '0)
          scaled[gi] = mode_reg ? pix_in[gi] : '0;
        else if (quot > PROD_W'(MAX_VAL))
          scaled[gi] = MAX_VAL;
        else
          scaled[gi] = quot[DATA_W-1:0];
      end
    end
  endgenerate

  logic [SUM_W-1:0]  mean_sum;
  logic [SUM_W-1:0]  mean_avg;
  logic [DATA_W-1:0] mean_max;

  assign mean_sum = SUM_W'(mean_reg[0]) + SUM_W'(mean_reg[1]) + SUM_W'(mean_reg[2]);
  assign mean_avg = mean_sum / SUM_W'(3);

  always_comb begin
    mean_max = mean_reg[0];
    if (mean_reg[1] > mean_max) mean_max = mean_reg[1];
    if (mean_reg[2] > mean_max) mean_max = mean_reg[2];
    if (mode_reg)
      ref_calc = (mean_avg > SUM_W'(MAX_VAL)) ? MAX_VAL : mean_avg[DATA_W-1:0];
    else
      ref_calc = mean_max;
  end

  always_ff @(posedge clk) begin
    // Reset and any unlisted state encoding share the same recovery path.
    if (rst || state_reg > DONE) begin
      state_reg    <= IDLE;
      mode_reg     <= 1'b0;
      issue_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_addr_reg  <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      we           <= 1'b0;
      addr_read    <= '0;
      addr_write   <= '0;
      ref_reg      <= '0;
      for (int i = 0; i < 3; i++) begin
        acc_reg[i]  <= '0;
        mean_reg[i] <= '0;
        out_reg[i]  <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          we        <= 1'b0;
          addr_read <= '0;
          if (start) begin
            state_reg    <= ACCUM;
            mode_reg     <= mode;
            busy         <= 1'b1;
            issue_reg    <= 1'b1;
            rd_valid_reg <= 1'b0;
            ref_reg      <= '0;
            for (int i = 0; i < 3; i++) begin
              acc_reg[i]  <= '0;
              mean_reg[i] <= '0;
            end
          end
        end

        ACCUM: begin
          rd_valid_reg <= issue_reg;
          if (issue_reg) begin
            if (addr_read == LAST_ADDR) begin
              issue_reg <= 1'b0;
              addr_read <= '0;
            end else begin
              addr_read <= addr_read + ADDR_W'(1);
            end
          end
          if (rd_valid_reg) begin
            for (int i = 0; i < 3; i++)
              acc_reg[i] <= acc_reg[i] + ACC_W'(pix_in[i]);
          end
          // Drain cycle: the last returned pixel is being added now.
          if (!issue_reg && rd_valid_reg)
            state_reg <= MEAN;
        end

        MEAN: begin
          for (int i = 0; i < 3; i++)
            mean_reg[i] <= mean_calc[i];
          state_reg <= REF;
        end

        REF: begin
          ref_reg      <= ref_calc;
          state_reg    <= SCALE;
          issue_reg    <= 1'b1;
          rd_valid_reg <= 1'b0;
          addr_read    <= '0;
        end

        SCALE: begin
          rd_valid_reg <= issue_reg;
          if (issue_reg) begin
            rd_addr_reg <= addr_read;
            if (addr_read == LAST_ADDR) begin
              issue_reg <= 1'b0;
              addr_read <= '0;
            end else begin
              addr_read <= addr_read + ADDR_W'(1);
            end
          end
          we <= rd_valid_reg;
          if (rd_valid_reg) begin
            addr_write <= rd_addr_reg;
            for (int i = 0; i < 3; i++)
              out_reg[i] <= scaled[i];
          end
          if (!issue_reg && !rd_valid_reg) begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end

        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          we        <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
